crc_code_decoder: RTL
=====================

# crc_code_decoder

Receive-side CRC-4 checker for the memory protection path. Accepts a 12-bit stored codeword (8 data bits in [11:4], 4 check bits in [3:0]) plus its 4-bit address on a start strobe. It serially recomputes the CRC-4 (polynomial x^4 + x + 1) over the 8 data bits, MSB first, using the same LFSR update as the encoder. It reports match or mismatch, the syndrome, and a saturating error count. It sits directly downstream of crc_code_encoder and memory read-out; its own sequencer replaces the encoder's external load/shift_en control.

## Interface
- ERR_CNT_W, 8, width of saturating error counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to check codeword_in/addr_in; accepted only when busy=0
- codeword_in  in  12  [11:4] data, [3:0] received CRC
- addr_in  in  4  address tag of the codeword
- busy  out  1  check in progress
- valid  out  1  one-cycle pulse: result outputs updated this cycle
- error  out  1  1 = recomputed CRC ≠ received CRC
- syndrome  out  4  recomputed CRC XOR received CRC
- data_out  out  8  captured data bits
- addr_out  out  4  captured address
- err_count  out  ERR_CNT_W  number of checks with error=1, saturating

## Operation
- State machine has two states: IDLE and SHIFT.
- IDLE behaviour: start=1 captures codeword_in and addr_in, clears the LFSR, clears the bit counter and moves to SHIFT. busy goes to 1.
- Captured data is held in data_out, and a separate 8-bit shift register is loaded from codeword_in[11:4].
- SHIFT, each cycle:
  - in = shift_reg[7]; shift_reg <= shift_reg << 1
  - lfsr <= {lfsr[2], lfsr[1], lfsr[3]^lfsr[0], lfsr[3]^in}
  - counter increments
- Last shift (counter = 7):
  - Compute the next LFSR value and compare it against the captured CRC.
  - Register syndrome, error and valid=1.
  - If error=1, increment err_count unless it is all-ones.
  - Return to IDLE; busy goes to 0.
- start while busy=1 is ignored; no queuing.
- syndrome, error, data_out and addr_out hold until the next completed check. data_out and addr_out update at capture.
- No correction is performed; error is detection only.

## Timing
- Reset (async assert, any state) forces:
  - busy, valid, error, counter, lfsr and state to 0/IDLE
  - syndrome, data_out, addr_out and err_count to 0
- An in-flight check is aborted with no valid pulse.
- Let the start-accepting edge be E0. Shifts occur on E1..E8.
- valid is high for exactly one cycle, between E8 and E9.
- busy is high from E0 to E8. valid rises on the same edge that busy falls.
- Earliest next accept is at E9, so throughput is one codeword per 9 cycles.
- start asserted on the E8 edge (busy still 1) is ignored.
- err_count updates on the same edge as valid. At saturation it stays at 2^ERR_CNT_W−1, with no wrap.

## Test plan
- Reset values: drive rst_n=0 mid-SHIFT (e.g. after E4).
  - All outputs go 0 immediately (asynchronously).
  - No valid pulse follows.
  - After release, IDLE accepts a new start.
- Clean codewords: feed 0xA58, 0x011, 0xFFD and 0x000 with various addresses.
  - Each gives valid 8 cycles after accept.
  - error=0 and syndrome=0.
  - data_out is 0xA5, 0x01, 0xFF and 0x00 respectively.
  - addr_out echoes the input address.
  - err_count stays 0.
- Single-bit CRC error: codeword 0xA59 → error=1, syndrome=0x1, err_count=1.
- Data-bit error: codeword 0xA48 → recomputed CRC of 0xA4 is 0x9, giving error=1, syndrome=0x1, data_out=0xA4.
- Start while busy: a second start at E3 with different data is ignored. The result matches the first codeword, and busy/valid timing is unchanged.
- Back-to-back and saturation:
  - start held high continuously accepts every 9 cycles.
  - With ERR_CNT_W=2, after 5 erroneous codewords err_count=3.

Source files
------------

// File: rtl/crc_code_decoder.sv
// crc_code_decoder
// Receive-side CRC-4 checker (x^4 + x + 1). A 12-bit stored codeword
// ({data[7:0], crc[3:0]}) and its address are captured on start. The data
// byte is then walked through the same serial LFSR the encoder uses, MSB
// first, one bit per clock. After the eighth bit the result is compared
// against the captured check bits, and syndrome/error/valid are registered.
// A saturating counter tracks how many checks failed.
//
// Handshake: start is sampled on a rising clock edge and is accepted only
// while busy=0 (FSM in IDLE). There is no queue and no backpressure. A start
// seen while busy=1 is dropped. valid is a single-cycle pulse. It rises on
// the same edge that busy falls, and it marks the cycle in which error and
// syndrome hold the new result. data_out and addr_out change at capture.
// error, syndrome, data_out and addr_out then hold until the next check
// overwrites them.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = SHIFT) so that external
// checkers can bind to it.

module crc_code_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [11:0]          codeword_in,
  input  logic [3:0]           addr_in,
  output logic                 busy,
  output logic                 valid,
  output logic                 error,
  output logic [3:0]           syndrome,
  output logic [7:0]           data_out,
  output logic [3:0]           addr_out,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // FSM state
  state_t r_state;
  state_t w_next_state;

  // Serial CRC datapath
  logic [7:0] r_shift;      // data bits still to be fed, MSB first
  logic [3:0] r_lfsr;       // running CRC remainder
  logic [2:0] r_cnt;        // index of the bit being shifted this cycle
  logic [3:0] r_crc_rx;     // check bits captured from the codeword

  // Result / reporting registers
  logic [7:0]           r_data;
  logic [3:0]           r_addr;
  logic                 r_valid;
  logic                 r_error;
  logic [3:0]           r_syndrome;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Control strobes decoded from the FSM
  logic       w_accept;     // start taken this edge
  logic       w_last;       // this edge shifts the final data bit
  logic       w_in_bit;     // data bit entering the LFSR
  logic [3:0] w_lfsr_next;  // LFSR value after this edge's shift
  logic [3:0] w_syndrome;   // final remainder XOR received check bits
  logic       w_mismatch;
  logic       w_err_sat;

  // LFSR update shared with the encoder: feedback from bit 3 enters
  // bit 0 (with the data bit) and bit 1 (with the old bit 0).
  assign w_in_bit    = r_shift[7];
  assign w_lfsr_next = {r_lfsr[2], r_lfsr[1], r_lfsr[3] ^ r_lfsr[0], r_lfsr[3] ^ w_in_bit};
  assign w_syndrome  = w_lfsr_next ^ r_crc_rx;
  assign w_mismatch  = |w_syndrome;
  assign w_err_sat   = &r_err_count;

  // Next-state and control decode; defaults hold state and idle the strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 3'd7) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture on accept, then shift one data bit per cycle through the LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= 8'h00;
      r_lfsr   <= 4'h0;
      r_cnt    <= 3'd0;
      r_crc_rx <= 4'h0;
      r_data   <= 8'h00;
      r_addr   <= 4'h0;
    end else if (w_accept) begin
      r_shift  <= codeword_in[11:4];
      r_lfsr   <= 4'h0;
      r_cnt    <= 3'd0;
      r_crc_rx <= codeword_in[3:0];
      r_data   <= codeword_in[11:4];
      r_addr   <= addr_in;
    end else if (r_state == SHIFT) begin
      r_shift  <= {r_shift[6:0], 1'b0};
      r_lfsr   <= w_lfsr_next;
      r_cnt    <= r_cnt + 3'd1;
    end
  end

  // Register the comparison on the last shift; valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_syndrome <= 4'h0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_error    <= w_mismatch;
        r_syndrome <= w_syndrome;
      end
    end
  end

  // Count failed checks, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_last && w_mismatch && !w_err_sat) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign busy      = (r_state == SHIFT);
  assign valid     = r_valid;
  assign error     = r_error;
  assign syndrome  = r_syndrome;
  assign data_out  = r_data;
  assign addr_out  = r_addr;
  assign err_count = r_err_count;
  assign dbg_state = r_state;

endmodule
